// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the MIPS unified memory port arbiter.
package mips_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // Arbiter sequencing: IDLE accepts a request, BUSY waits out memory latency
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Which requester owns the access currently in flight
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/arb_latency_timer.sv
// Load-on-issue latency counter: loads 1 when an access issues, counts up
// each cycle and flags done when the memory read latency has elapsed.
module arb_latency_timer #(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LAT_VAL = CW'(MEM_LAT);
  localparam logic [CW-1:0] ONE_VAL = CW'(1);

  logic [CW-1:0] cnt_reg;

  // Count from issue until the latency is reached, then park at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= ONE_VAL;
    end else if (done) begin
      cnt_reg <= '0;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg + ONE_VAL;
    end
  end

  assign done = (cnt_reg == LAT_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the MIPS core: shares one memory port
// between instruction fetch and load/store, one access at a time, and
// returns read data / store acknowledge with a one-cycle valid pulse.
// Optional build macro: ARB_FAIRNESS_EN bounds how many consecutive data
// accesses may be granted while a fetch is waiting.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_LAT    = 2,
  parameter int FAIR_LIMIT = 4
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pc_stall
);

  state_t            state_reg;
  owner_t            owner_reg;
  logic              store_reg;
  logic              if_valid_reg;
  logic              dm_valid_reg;
  logic [DATA_W-1:0] if_rdata_reg;
  logic [DATA_W-1:0] dm_rdata_reg;

  logic idle_ok;
  logic fair_take;
  logic dm_win;
  logic if_win;
  logic timer_done;
  logic access_done;

`ifdef ARB_FAIRNESS_EN
  localparam int SW = $clog2(FAIR_LIMIT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(FAIR_LIMIT);
  localparam logic [SW-1:0] STREAK_ONE = SW'(1);

  logic [SW-1:0] streak_reg;

  // A fetch that has watched FAIR_LIMIT data grants in a row takes the port
  assign fair_take = if_req && (streak_reg == STREAK_MAX);

  // Track consecutive data grants made while a fetch is waiting
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      streak_reg <= '0;
    end else if (if_gnt) begin
      streak_reg <= '0;
    end else if (dm_gnt && if_req) begin
      if (streak_reg != STREAK_MAX) begin
        streak_reg <= streak_reg + STREAK_ONE;
      end
    end else if ((state_reg == IDLE) && !if_req) begin
      streak_reg <= '0;
    end
  end
`else
  // Strict data-side priority: fetch may starve while dm_req stays high
  assign fair_take = 1'b0;
`endif

  // Arbitration happens only in IDLE and never while reset is asserted
  assign idle_ok = ~RESET & (state_reg == IDLE);
  assign dm_win  = dm_req & ~fair_take;
  assign if_win  = if_req & ~dm_win;
  assign dm_gnt  = idle_ok & dm_win;
  assign if_gnt  = idle_ok & if_win;

  // Memory command comes straight from the winner in the grant cycle
  assign mem_en    = if_gnt | dm_gnt;
  assign mem_we    = dm_we & dm_gnt;
  assign mem_addr  = dm_gnt ? dm_addr : if_addr;
  assign mem_wdata = dm_wdata;
  assign pc_stall  = if_req & ~if_gnt;

  arb_latency_timer #(
    .MEM_LAT (MEM_LAT)
  ) u_timer (
    .clk  (CLOCK_50),
    .rst  (RESET),
    .load (mem_en),
    .done (timer_done)
  );

  assign access_done = (state_reg == BUSY) && timer_done;

  // Sequencer: latch owner and access type on issue, release on completion
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_reg <= IDLE;
      owner_reg <= OWN_IF;
      store_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (mem_en) begin
            state_reg <= BUSY;
            owner_reg <= dm_gnt ? OWN_DM : OWN_IF;
            store_reg <= mem_we;
          end
        end
        BUSY: begin
          if (timer_done) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Return path: capture read data and pulse the owner's valid for one cycle
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      if_valid_reg <= 1'b0;
      dm_valid_reg <= 1'b0;
      if_rdata_reg <= '0;
      dm_rdata_reg <= '0;
    end else begin
      if_valid_reg <= 1'b0;
      dm_valid_reg <= 1'b0;
      if (access_done) begin
        if (owner_reg == OWN_IF) begin
          if_valid_reg <= 1'b1;
          if_rdata_reg <= mem_rdata;
        end else begin
          dm_valid_reg <= 1'b1;
          if (!store_reg) begin
            dm_rdata_reg <= mem_rdata;
          end
        end
      end
    end
  end

  assign if_valid = if_valid_reg;
  assign dm_valid = dm_valid_reg;
  assign if_rdata = if_rdata_reg;
  assign dm_rdata = dm_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// random traffic, all compared against a transaction-level reference that
// schedules each access by cycle arithmetic (port free again LAT+1 cycles
// after a grant, result due in that same cycle).
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int FL  = 4;
`ifdef ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_valid;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_valid;
  logic [DW-1:0] dm_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          pc_stall;

  mem_port_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .MEM_LAT    (LAT),
    .FAIR_LIMIT (FL)
  ) dut (
    .CLOCK_50  (clk),
    .RESET     (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_valid  (if_valid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_valid  (dm_valid),
    .dm_rdata  (dm_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .pc_stall  (pc_stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Memory environment: 128 words, read data appears LAT cycles after issue
  logic [31:0] tb_mem [0:127];
  bit          pv1 = 1'b0, pv2 = 1'b0;
  logic [6:0]  pa1 = '0, pa2 = '0;

  // Reference model state
  int          free_at   = 0;
  int          streak    = 0;
  bit          ev_on     = 1'b0;
  int          ev_cyc    = 0;
  bit          ev_if     = 1'b0;
  bit          ev_store  = 1'b0;
  logic [31:0] ev_data   = '0;
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_dm_rdata = '0;
  int          model_dm_grants = 0;
  int          model_if_grants = 0;
  int          obs_dm_gnts = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%08h expected=%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, then predict and compare at the falling edge
  task automatic cycle(input bit r, input bit ir, input logic [31:0] ia,
                       input bit dr, input bit dwe, input logic [31:0] da,
                       input logic [31:0] dwd);
    bit          e_ifv;
    bit          e_dmv;
    bit          e_ifg;
    bit          e_dmg;
    bit          take_if;
    logic [31:0] a_sel;
    e_ifv = 1'b0; e_dmv = 1'b0; e_ifg = 1'b0; e_dmg = 1'b0;
    @(posedge clk);
    #1;
    rst      = r;
    if_req   = ir;
    if_addr  = ia;
    dm_req   = dr;
    dm_we    = dwe;
    dm_addr  = da;
    dm_wdata = dwd;
    mem_rdata = pv2 ? tb_mem[pa2] : $urandom();
    @(negedge clk);

    if (r) begin
      ev_on = 1'b0;
      streak = 0;
      exp_if_rdata = '0;
      exp_dm_rdata = '0;
      free_at = cyc + 1;
    end else begin
      if (ev_on && ev_cyc == cyc) begin
        ev_on = 1'b0;
        if (ev_if) begin
          e_ifv = 1'b1;
          exp_if_rdata = ev_data;
        end else begin
          e_dmv = 1'b1;
          if (!ev_store) exp_dm_rdata = ev_data;
        end
      end
      if (cyc >= free_at) begin
        take_if = ir && FAIR && (streak == FL);
        if (dr && !take_if) e_dmg = 1'b1;
        else if (ir)        e_ifg = 1'b1;
        if (e_dmg || e_ifg) begin
          a_sel    = e_dmg ? da : ia;
          free_at  = cyc + LAT + 1;
          ev_on    = 1'b1;
          ev_cyc   = cyc + LAT + 1;
          ev_if    = e_ifg;
          ev_store = e_dmg && dwe;
          ev_data  = tb_mem[a_sel[8:2]];
        end
        if (e_dmg && ir)  streak = (streak < FL) ? streak + 1 : FL;
        else if (e_ifg)   streak = 0;
        else if (!ir)     streak = 0;
        if (e_dmg) model_dm_grants++;
        if (e_ifg) model_if_grants++;
      end
    end

    check("if_gnt",   {31'b0, if_gnt},   {31'b0, e_ifg});
    check("dm_gnt",   {31'b0, dm_gnt},   {31'b0, e_dmg});
    check("mem_en",   {31'b0, mem_en},   {31'b0, e_ifg | e_dmg});
    check("mem_we",   {31'b0, mem_we},   {31'b0, e_dmg & dwe});
    check("pc_stall", {31'b0, pc_stall}, {31'b0, ir & ~e_ifg});
    check("if_valid", {31'b0, if_valid}, {31'b0, e_ifv});
    check("dm_valid", {31'b0, dm_valid}, {31'b0, e_dmv});
    check("valid_onehot", {31'b0, if_valid & dm_valid}, 32'd0);
    check("if_rdata", if_rdata, exp_if_rdata);
    check("dm_rdata", dm_rdata, exp_dm_rdata);
    if (e_ifg || e_dmg) check("mem_addr", mem_addr, e_dmg ? da : ia);
    if (e_dmg && dwe)   check("mem_wdata", mem_wdata, dwd);

    if (dm_gnt) obs_dm_gnts++;
    if (mem_en && mem_we) tb_mem[mem_addr[8:2]] = mem_wdata;
    pv2 = pv1;
    pa2 = pa1;
    pv1 = mem_en & ~mem_we;
    pa1 = mem_addr[8:2];
    $display("cyc %0d rst=%0b ifreq=%0b dmreq=%0b we=%0b ifgnt=%0b dmgnt=%0b ifv=%0b dmv=%0b ifrd=%08h dmrd=%08h",
             cyc, r, ir, dr, dwe, if_gnt, dm_gnt, if_valid, dm_valid, if_rdata, dm_rdata);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  int          dm_base;
  int          if_base;
  int          obs_base;
  int          dm_at_if;
  bit          ir_s;
  bit          dr_s;
  bit          starve_done;
  logic [31:0] ra;
  logic [31:0] rb;

  initial begin
    for (int i = 0; i < 128; i++) tb_mem[i] = $urandom();
    rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_rdata = '0;

    // Reset state
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    idle(2);

    // Single fetch
    tb_mem[4] = 32'h8C220004;
    cycle(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, '0, '0);
    idle(4);

    // Fetch and load contend in the same cycle; fetch holds until granted
    cycle(1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 32'h100, '0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, '0, '0);
    idle(4);

    // Store: acknowledge pulses, load data register untouched
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF);
    idle(4);

    // Starvation: data held for six accesses while fetch waits
    dm_base = model_dm_grants;
    if_base = model_if_grants;
    obs_base = obs_dm_gnts;
    dm_at_if = -1;
    starve_done = 1'b0;
    for (int k = 0; k < 80 && !starve_done; k++) begin
      ir_s = (model_if_grants == if_base);
      dr_s = (model_dm_grants - dm_base) < 6;
      if (!ir_s && !dr_s && !ev_on) begin
        starve_done = 1'b1;
      end else begin
        ra = {23'b0, 7'($urandom_range(0, 127)), 2'b00};
        cycle(1'b0, ir_s, 32'h40, dr_s, 1'b0, ra, '0);
        if (if_gnt && dm_at_if < 0) dm_at_if = obs_dm_gnts - obs_base;
      end
    end
    check("starve_finished", {31'b0, starve_done}, 32'd1);
    check("starve_dm_before_if", dm_at_if, FAIR ? 32'd4 : 32'd6);
    idle(2);

    // Reset during a fetch's BUSY phase, then a fresh fetch
    cycle(1'b0, 1'b1, 32'h30, 1'b0, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    idle(4);
    cycle(1'b0, 1'b1, 32'h34, 1'b0, 1'b0, '0, '0);
    idle(4);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      ra = {23'b0, 7'($urandom_range(0, 127)), 2'b00};
      rb = {23'b0, 7'($urandom_range(0, 127)), 2'b00};
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), ra,
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0), rb, $urandom());
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
